modbus_reg_file: RTL and testbench

//  Parametrised Modbus RTU slave register file: NUM_HOLD holding regs (FC03/06/16), NUM_INPUT input regs (FC04).

---
 rtl/modbus_pkg.sv | 27 ++
 rtl/modbus_reg_file_if.sv | 32 +++
 rtl/modbus_range_check.sv | 58 +++++
 rtl/modbus_reg_file.sv | 196 +++++++++++++++++++
 tb/tb_modbus_reg_file.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/modbus_pkg.sv
// Shared constants for the Modbus RTU register file: function codes, exception codes, FSM states.
package modbus_pkg;

  localparam logic [7:0] FC_READ_HOLD   = 8'h03;
  localparam logic [7:0] FC_READ_INPUT  = 8'h04;
  localparam logic [7:0] FC_WRITE_ONE   = 8'h06;
  localparam logic [7:0] FC_WRITE_MULTI = 8'h10;

  localparam logic [7:0] EXC_NONE          = 8'h00;
  localparam logic [7:0] EXC_ILLEGAL_FUNC  = 8'h01;
  localparam logic [7:0] EXC_ILLEGAL_ADDR  = 8'h02;
  localparam logic [7:0] EXC_ILLEGAL_VALUE = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_t;

  function automatic logic is_supported(input logic [7:0] func);
    return (func == FC_READ_HOLD) || (func == FC_READ_INPUT) ||
           (func == FC_WRITE_ONE) || (func == FC_WRITE_MULTI);
  endfunction

endpackage

// File: rtl/modbus_reg_file_if.sv
// Request / write-word / read-word / response handshakes between the frame logic and the register file.
interface modbus_reg_file_if;

  logic        req_vld;
  logic        req_rdy;
  logic [7:0]  req_func;
  logic [15:0] req_addr;
  logic [15:0] req_qty;

  logic        wr_vld;
  logic        wr_rdy;
  logic [15:0] wr_data;

  logic        rd_vld;
  logic        rd_rdy;
  logic [15:0] rd_data;
  logic        rd_last;

  logic        rsp_vld;
  logic [7:0]  rsp_exc;

  modport slave (
    input  req_vld, req_func, req_addr, req_qty, wr_vld, wr_data, rd_rdy,
    output req_rdy, wr_rdy, rd_vld, rd_data, rd_last, rsp_vld, rsp_exc
  );

  modport master (
    output req_vld, req_func, req_addr, req_qty, wr_vld, wr_data, rd_rdy,
    input  req_rdy, wr_rdy, rd_vld, rd_data, rd_last, rsp_vld, rsp_exc
  );

endinterface

// File: rtl/modbus_range_check.sv
// Combinational request validation: returns the Modbus exception code for a latched request.
module modbus_range_check
  import modbus_pkg::*;
#(
  parameter int                  NUM_HOLD   = 8,
  parameter int                  NUM_INPUT  = 8,
  parameter logic [15:0]         HOLD_BASE  = 16'h0000,
  parameter logic [15:0]         INPUT_BASE = 16'h0000,
  parameter int                  MAX_RD_QTY = 125,
  parameter int                  MAX_WR_QTY = 123,
  parameter logic [NUM_HOLD-1:0] WR_MASK    = '1
) (
  input  logic [7:0]  func,
  input  logic [15:0] addr,
  input  logic [15:0] qty,
  output logic [7:0]  exc
);

  logic        is_rd;
  logic        is_wr;
  logic        qty_bad;
  logic        protect_hit;
  logic [16:0] base;
  logic [16:0] num;
  logic [16:0] off;
  logic [16:0] span;

  // 17-bit offset/span so a start address near 0xFFFF cannot wrap back into range
  always_comb begin
    is_rd   = (func == FC_READ_HOLD) || (func == FC_READ_INPUT);
    is_wr   = (func == FC_WRITE_ONE) || (func == FC_WRITE_MULTI);
    qty_bad = (is_rd && ((qty == 16'd0) || (qty > 16'(MAX_RD_QTY)))) ||
              ((func == FC_WRITE_MULTI) && ((qty == 16'd0) || (qty > 16'(MAX_WR_QTY))));
    base    = (func == FC_READ_INPUT) ? {1'b0, INPUT_BASE} : {1'b0, HOLD_BASE};
    num     = (func == FC_READ_INPUT) ? 17'(NUM_INPUT) : 17'(NUM_HOLD);
    off     = {1'b0, addr} - base;
    span    = off + {1'b0, qty};

    protect_hit = 1'b0;
    for (int i = 0; i < NUM_HOLD; i++) begin
      if ((17'(i) >= off) && (17'(i) < span) && !WR_MASK[i]) begin
        protect_hit = 1'b1;
      end
    end

    exc = EXC_NONE;
    if (!is_supported(func)) begin
      exc = EXC_ILLEGAL_FUNC;
    end else if (qty_bad) begin
      exc = EXC_ILLEGAL_VALUE;
    end else if (({1'b0, addr} < base) || (span > num)) begin
      exc = EXC_ILLEGAL_ADDR;
    end else if (is_wr && protect_hit) begin
      exc = EXC_ILLEGAL_ADDR;
    end
  end

endmodule

// File: rtl/modbus_reg_file.sv
// Modbus RTU slave register file: holding regs (FC03/06/16) and input regs (FC04) with
// snapshot reads, staged atomic multi-register writes and exception reporting.
module modbus_reg_file
  import modbus_pkg::*;
#(
  parameter int                     NUM_HOLD   = 8,
  parameter int                     NUM_INPUT  = 8,
  parameter logic [15:0]            HOLD_BASE  = 16'h0000,
  parameter logic [15:0]            INPUT_BASE = 16'h0000,
  parameter int                     MAX_RD_QTY = 125,
  parameter int                     MAX_WR_QTY = 123,
  parameter logic [NUM_HOLD-1:0]    WR_MASK    = '1,
  parameter logic [NUM_HOLD*16-1:0] HOLD_RST   = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      abort,
  modbus_reg_file_if.slave          bus,
  output logic [NUM_HOLD*16-1:0]    hold_regs_o,
  output logic [NUM_HOLD-1:0]       hold_update,
  input  logic [NUM_INPUT*16-1:0]   inp_regs_i
);

  localparam int HW = (NUM_HOLD > 1) ? $clog2(NUM_HOLD) : 1;
  localparam int IW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;

  state_t              state;
  logic [7:0]          func_q;
  logic [15:0]         addr_q;
  logic [15:0]         qty_q;
  logic [15:0]         cnt_q;
  logic [15:0]         hold_q  [NUM_HOLD];
  logic [15:0]         stage_q [NUM_HOLD];
  logic [15:0]         snap_q  [NUM_INPUT];
  logic [NUM_HOLD-1:0] stage_mask;
  logic [7:0]          chk_exc;

  logic [15:0]         rd_pos;
  logic [HW-1:0]       rd_hidx;
  logic [IW-1:0]       rd_iidx;
  logic [HW-1:0]       wr_hidx;
  logic [15:0]         rd_word;
  logic                rd_fire;
  logic                wr_fire;
  logic                last_word;

  modbus_range_check #(
    .NUM_HOLD   (NUM_HOLD),
    .NUM_INPUT  (NUM_INPUT),
    .HOLD_BASE  (HOLD_BASE),
    .INPUT_BASE (INPUT_BASE),
    .MAX_RD_QTY (MAX_RD_QTY),
    .MAX_WR_QTY (MAX_WR_QTY),
    .WR_MASK    (WR_MASK)
  ) u_range_check (
    .func (func_q),
    .addr (addr_q),
    .qty  (qty_q),
    .exc  (chk_exc)
  );

  // rd_pos is the word about to be loaded into rd_data: word 0 from CHECK, else the next one
  always_comb begin
    rd_pos    = (state == ST_CHECK) ? 16'd0 : cnt_q + 16'd1;
    rd_hidx   = HW'(addr_q - HOLD_BASE + rd_pos);
    rd_iidx   = IW'(addr_q - INPUT_BASE + rd_pos);
    wr_hidx   = HW'(addr_q - HOLD_BASE + cnt_q);
    rd_word   = (func_q == FC_READ_INPUT) ? snap_q[rd_iidx] : hold_q[rd_hidx];
    rd_fire   = bus.rd_vld & bus.rd_rdy;
    wr_fire   = bus.wr_vld & bus.wr_rdy;
    last_word = (cnt_q == qty_q - 16'd1);
  end

  for (genvar gi = 0; gi < NUM_HOLD; gi++) begin : g_hold_out
    assign hold_regs_o[gi*16 +: 16] = hold_q[gi];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      bus.req_rdy <= 1'b1;
      bus.wr_rdy  <= 1'b0;
      bus.rd_vld  <= 1'b0;
      bus.rd_last <= 1'b0;
      bus.rd_data <= 16'd0;
      bus.rsp_vld <= 1'b0;
      bus.rsp_exc <= EXC_NONE;
      hold_update <= '0;
      stage_mask  <= '0;
      func_q      <= 8'd0;
      addr_q      <= 16'd0;
      qty_q       <= 16'd0;
      cnt_q       <= 16'd0;
      for (int i = 0; i < NUM_HOLD; i++) begin
        hold_q[i]  <= HOLD_RST[i*16 +: 16];
        stage_q[i] <= 16'd0;
      end
      for (int i = 0; i < NUM_INPUT; i++) begin
        snap_q[i] <= 16'd0;
      end
    end else begin
      bus.rsp_vld <= 1'b0;
      hold_update <= '0;
      if (abort && (state != ST_IDLE)) begin
        state       <= ST_IDLE;
        bus.req_rdy <= 1'b1;
        bus.rd_vld  <= 1'b0;
        bus.rd_last <= 1'b0;
        bus.wr_rdy  <= 1'b0;
        bus.rsp_exc <= EXC_NONE;
        stage_mask  <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.req_vld) begin
              func_q      <= bus.req_func;
              addr_q      <= bus.req_addr;
              qty_q       <= (bus.req_func == FC_WRITE_ONE) ? 16'd1 : bus.req_qty;
              bus.req_rdy <= 1'b0;
              state       <= ST_CHECK;
              for (int i = 0; i < NUM_INPUT; i++) begin
                snap_q[i] <= inp_regs_i[i*16 +: 16];
              end
            end
          end
          ST_CHECK: begin
            cnt_q <= 16'd0;
            if (chk_exc != EXC_NONE) begin
              bus.rsp_vld <= 1'b1;
              bus.rsp_exc <= chk_exc;
              state       <= ST_RESP;
            end else if ((func_q == FC_READ_HOLD) || (func_q == FC_READ_INPUT)) begin
              bus.rd_vld  <= 1'b1;
              bus.rd_data <= rd_word;
              bus.rd_last <= (qty_q == 16'd1);
              state       <= ST_READ;
            end else begin
              bus.wr_rdy <= 1'b1;
              stage_mask <= '0;
              state      <= ST_WRITE;
            end
          end
          ST_READ: begin
            if (rd_fire) begin
              if (bus.rd_last) begin
                bus.rd_vld  <= 1'b0;
                bus.rd_last <= 1'b0;
                bus.rsp_vld <= 1'b1;
                bus.rsp_exc <= EXC_NONE;
                state       <= ST_RESP;
              end else begin
                cnt_q       <= cnt_q + 16'd1;
                bus.rd_data <= rd_word;
                bus.rd_last <= (rd_pos == qty_q - 16'd1);
              end
            end
          end
          ST_WRITE: begin
            if (wr_fire) begin
              if (last_word) begin
                // Final word bypasses the shadow buffer so every staged reg lands on the same edge
                for (int i = 0; i < NUM_HOLD; i++) begin
                  if (HW'(i) == wr_hidx) begin
                    hold_q[i] <= bus.wr_data;
                  end else if (stage_mask[i]) begin
                    hold_q[i] <= stage_q[i];
                  end
                end
                hold_update <= stage_mask | (NUM_HOLD'(1) << wr_hidx);
                stage_mask  <= '0;
                bus.wr_rdy  <= 1'b0;
                bus.rsp_vld <= 1'b1;
                bus.rsp_exc <= EXC_NONE;
                state       <= ST_RESP;
              end else begin
                stage_q[wr_hidx]    <= bus.wr_data;
                stage_mask[wr_hidx] <= 1'b1;
                cnt_q               <= cnt_q + 16'd1;
              end
            end
          end
          ST_RESP: begin
            bus.rsp_exc <= EXC_NONE;
            bus.req_rdy <= 1'b1;
            state       <= ST_IDLE;
          end
          default: begin
            bus.req_rdy <= 1'b1;
            state       <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modbus_reg_file.sv
// Self-checking bench for modbus_reg_file: directed cases then randomized requests against a register model.
module tb_modbus_reg_file;

  localparam int NH = 8;
  localparam int NI = 8;
  localparam logic [NH-1:0] MASK = 8'b1011_1111;
  localparam logic [NH*16-1:0] RST_IMG = {16'hA007, 16'hA006, 16'hA005, 16'h3333,
                                          16'h2222, 16'h1111, 16'hA001, 16'hA000};

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              abort = 1'b0;
  logic [NH*16-1:0]  hold_regs;
  logic [NH-1:0]     hold_update;
  logic [NI*16-1:0]  inp_regs;

  modbus_reg_file_if bus();

  modbus_reg_file #(
    .NUM_HOLD   (NH),
    .NUM_INPUT  (NI),
    .HOLD_BASE  (16'h0000),
    .INPUT_BASE (16'h0000),
    .MAX_RD_QTY (125),
    .MAX_WR_QTY (123),
    .WR_MASK    (MASK),
    .HOLD_RST   (RST_IMG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .abort       (abort),
    .bus         (bus),
    .hold_regs_o (hold_regs),
    .hold_update (hold_update),
    .inp_regs_i  (inp_regs)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_hold [NH];
  logic [15:0] wr_words [256];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int r = 0; r < NH; r++) f[r*16 +: 16] = model_hold[r];
    return f;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NH; r++) model_hold[r] = RST_IMG[r*16 +: 16];
  endtask

  // Exception rules: unsupported code, bad quantity, range overrun, read-only target
  function automatic int exp_exc(input int func, input int addr, input int qty);
    int q;
    q = (func == 6) ? 1 : qty;
    if (!(func == 3 || func == 4 || func == 6 || func == 16)) return 1;
    if ((func == 3 || func == 4) && (q < 1 || q > 125)) return 3;
    if (func == 16 && (q < 1 || q > 123)) return 3;
    if (addr + q > 8) return 2;
    if (func == 6 || func == 16) begin
      for (int r = addr; r < addr + q; r++) if (!MASK[r]) return 2;
    end
    return 0;
  endfunction

  task automatic apply_stimulus(input logic [7:0] func, input logic [15:0] addr, input logic [15:0] qty,
                                input int gap_pct, input int abort_after, input string tag);
    int          exc, q, k, n, wait_n;
    logic [15:0] snap [NI];
    logic [15:0] exp_rd [$];
    logic [NH-1:0] upd;
    logic        is_rd, is_wr, done, hs_rd, hs_wr;
    exc   = exp_exc(int'(func), int'(addr), int'(qty));
    q     = (func == 8'h06) ? 1 : int'(qty);
    is_rd = (exc == 0) && (func == 8'h03 || func == 8'h04);
    is_wr = (exc == 0) && (func == 8'h06 || func == 8'h10);
    wait_n = 0;
    while (bus.req_rdy !== 1'b1 && wait_n < 20) begin
      step();
      wait_n++;
    end
    check_output({tag, "_ready"}, bus.req_rdy, 1);
    bus.req_vld  = 1'b1;
    bus.req_func = func;
    bus.req_addr = addr;
    bus.req_qty  = qty;
    for (int r = 0; r < NI; r++) snap[r] = inp_regs[r*16 +: 16];
    if (is_rd) begin
      for (int i = 0; i < q; i++)
        exp_rd.push_back((func == 8'h04) ? snap[int'(addr) + i] : model_hold[int'(addr) + i]);
    end
    step();
    bus.req_vld  = 1'b0;
    bus.req_func = 8'($urandom);
    inp_regs     = {$urandom, $urandom, $urandom, $urandom};
    check_output({tag, "_busy"}, bus.req_rdy, 0);
    k = 0;
    n = 1;
    done = 1'b0;
    while (!done && n < 400) begin
      if (abort_after >= 0 && k == abort_after && n >= 2) begin
        abort        = 1'b1;
        bus.rd_rdy   = 1'b1;
        bus.wr_vld   = is_wr && (k < q);
        bus.wr_data  = wr_words[k];
        step();
        abort      = 1'b0;
        bus.rd_rdy = 1'b0;
        bus.wr_vld = 1'b0;
        check_output({tag, "_abort_rsp"}, bus.rsp_vld, 0);
        check_output({tag, "_abort_idle"}, bus.req_rdy, 1);
        check_output({tag, "_abort_rd"}, bus.rd_vld, 0);
        check_output({tag, "_abort_wr"}, bus.wr_rdy, 0);
        check_output({tag, "_abort_hold"}, hold_regs, model_flat());
        check_output({tag, "_abort_upd"}, hold_update, 0);
        done = 1'b1;
      end else begin
        bus.rd_rdy  = ($urandom_range(99) >= gap_pct);
        bus.wr_vld  = is_wr && (k < q) && ($urandom_range(99) >= gap_pct);
        bus.wr_data = wr_words[k];
        hs_rd = bus.rd_vld && bus.rd_rdy;
        hs_wr = bus.wr_rdy && bus.wr_vld;
        if (hs_rd) begin
          if (k < q) begin
            check_output({tag, "_rd_data"}, bus.rd_data, exp_rd[k]);
            check_output({tag, "_rd_last"}, bus.rd_last, (k == q - 1));
          end else begin
            check_output({tag, "_rd_extra"}, bus.rd_vld, 0);
          end
          k++;
        end
        if (hs_wr) k++;
        step();
        n++;
        if (exc != 0) begin
          check_output({tag, "_exc_rd"}, bus.rd_vld, 0);
          check_output({tag, "_exc_wr"}, bus.wr_rdy, 0);
          check_output({tag, "_exc_upd"}, hold_update, 0);
          if (n == 2) begin
            check_output({tag, "_exc_vld"}, bus.rsp_vld, 1);
            check_output({tag, "_exc_code"}, bus.rsp_exc, exc);
            check_output({tag, "_exc_hold"}, hold_regs, model_flat());
            done = 1'b1;
          end
        end else if ((hs_rd || hs_wr) && k == q) begin
          check_output({tag, "_rsp_vld"}, bus.rsp_vld, 1);
          check_output({tag, "_rsp_exc"}, bus.rsp_exc, 0);
          upd = '0;
          if (is_wr) begin
            for (int i = 0; i < q; i++) begin
              model_hold[int'(addr) + i] = wr_words[i];
              upd[int'(addr) + i] = 1'b1;
            end
          end
          check_output({tag, "_commit"}, hold_regs, model_flat());
          check_output({tag, "_upd"}, hold_update, upd);
          done = 1'b1;
        end else begin
          check_output({tag, "_no_rsp"}, bus.rsp_vld, 0);
          check_output({tag, "_hold_stable"}, hold_regs, model_flat());
          check_output({tag, "_no_upd"}, hold_update, 0);
          if (n == 2) begin
            check_output({tag, "_rd_start"}, bus.rd_vld, is_rd);
            check_output({tag, "_wr_start"}, bus.wr_rdy, is_wr);
          end
        end
      end
    end
    if (!done) begin
      check_output({tag, "_timeout"}, done, 1);
      abort = 1'b1;
      step();
      abort = 1'b0;
    end else if (abort_after < 0) begin
      step();
      check_output({tag, "_rsp_pulse"}, bus.rsp_vld, 0);
      check_output({tag, "_back_idle"}, bus.req_rdy, 1);
    end
  endtask

  initial begin
    logic [7:0]  func;
    logic [15:0] addr, qty;
    int          sel, ab, q;
    bus.req_vld  = 1'b0;
    bus.req_func = 8'd0;
    bus.req_addr = 16'd0;
    bus.req_qty  = 16'd0;
    bus.wr_vld   = 1'b0;
    bus.wr_data  = 16'd0;
    bus.rd_rdy   = 1'b0;
    inp_regs     = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    for (int i = 0; i < 256; i++) wr_words[i] = 16'($urandom);

    #2 rst_n = 1'b0;
    step();
    step();
    check_output("rst_req_rdy", bus.req_rdy, 1);
    check_output("rst_wr_rdy", bus.wr_rdy, 0);
    check_output("rst_rd_vld", bus.rd_vld, 0);
    check_output("rst_rd_last", bus.rd_last, 0);
    check_output("rst_rd_data", bus.rd_data, 0);
    check_output("rst_rsp_vld", bus.rsp_vld, 0);
    check_output("rst_rsp_exc", bus.rsp_exc, 0);
    check_output("rst_hold", hold_regs, model_flat());
    check_output("rst_upd", hold_update, 0);
    rst_n = 1'b1;
    step();

    $display("[TB] directed cases");
    apply_stimulus(8'h03, 16'd2, 16'd3, 0, -1, "fc03_basic");
    wr_words[0] = 16'hABCD;
    wr_words[1] = 16'h1234;
    apply_stimulus(8'h10, 16'd0, 16'd2, 50, -1, "fc16_gaps");
    apply_stimulus(8'h04, 16'd0, 16'd2, 50, -1, "fc04_snap");
    apply_stimulus(8'h03, 16'd7, 16'd2, 0, -1, "fc03_range");
    apply_stimulus(8'h05, 16'd0, 16'd1, 0, -1, "fc05_func");
    apply_stimulus(8'h03, 16'd0, 16'd0, 0, -1, "fc03_qty0");
    apply_stimulus(8'h06, 16'd6, 16'd1, 0, -1, "fc06_protect");
    for (int i = 0; i < 8; i++) wr_words[i] = 16'($urandom);
    apply_stimulus(8'h10, 16'd0, 16'd3, 30, 2, "fc16_abort");
    apply_stimulus(8'h03, 16'd0, 16'd3, 0, -1, "fc03_after_abort");
    apply_stimulus(8'h10, 16'd3, 16'd2, 0, 1, "fc16_abort_last");
    apply_stimulus(8'h10, 16'd0, 16'd124, 0, -1, "fc16_qty_max");
    apply_stimulus(8'h03, 16'd0, 16'd126, 0, -1, "fc03_qty_max");
    apply_stimulus(8'h03, 16'd0, 16'd125, 0, -1, "fc03_qty_range");
    apply_stimulus(8'h03, 16'd0, 16'd8, 40, -1, "fc03_full");
    apply_stimulus(8'h10, 16'hFFFF, 16'd2, 0, -1, "fc16_wrap");
    apply_stimulus(8'h06, 16'd5, 16'd0, 0, -1, "fc06_qty_ignored");

    $display("[TB] randomized requests");
    for (int t = 0; t < 40; t++) begin
      sel = $urandom_range(9);
      if (sel <= 2)      func = 8'h03;
      else if (sel <= 4) func = 8'h04;
      else if (sel <= 6) func = 8'h10;
      else if (sel == 7) func = 8'h06;
      else               func = 8'($urandom_range(255));
      addr = ($urandom_range(9) == 0) ? 16'(16'hFFF0 + $urandom_range(15)) : 16'($urandom_range(9));
      qty  = ($urandom_range(9) == 0) ? 16'($urandom_range(130, 120)) : 16'($urandom_range(9));
      for (int i = 0; i < 16; i++) wr_words[i] = 16'($urandom);
      q  = (func == 8'h06) ? 1 : int'(qty);
      ab = -1;
      if (exp_exc(int'(func), int'(addr), int'(qty)) == 0 && $urandom_range(4) == 0)
        ab = $urandom_range(q - 1);
      apply_stimulus(func, addr, qty, $urandom_range(60), ab, "rand");
    end

    abort = 1'b1;
    step();
    abort = 1'b0;
    check_output("idle_abort_rdy", bus.req_rdy, 1);
    check_output("idle_abort_rsp", bus.rsp_vld, 0);
    check_output("idle_abort_hold", hold_regs, model_flat());

    bus.req_vld  = 1'b1;
    bus.req_func = 8'h10;
    bus.req_addr = 16'd0;
    bus.req_qty  = 16'd2;
    step();
    bus.req_vld = 1'b0;
    step();
    check_output("mid_wr_rdy", bus.wr_rdy, 1);
    bus.wr_vld  = 1'b1;
    bus.wr_data = 16'h5A5A;
    step();
    bus.wr_vld = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("mid_rst_hold", hold_regs, model_flat());
    check_output("mid_rst_rdy", bus.req_rdy, 1);
    check_output("mid_rst_wr", bus.wr_rdy, 0);
    check_output("mid_rst_rsp", bus.rsp_vld, 0);
    step();
    rst_n = 1'b1;
    apply_stimulus(8'h03, 16'd0, 16'd8, 20, -1, "fc03_post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
